// File: rtl/pc_sequencer.sv
// Program counter sequencer for the 16-bit pipelined RISC core.
// Chooses one fetch action per cycle: load a new target, hold the PC, or let it increment.
// Drives the pipeline flush strobes and keeps the interrupt return address.
module pc_sequencer #(
    parameter int unsigned     AddrW     = 13,
    parameter logic [AddrW-1:0] IntVector = 'h1F00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req_i,
    input  logic             branch_en_i,
    input  logic [AddrW-1:0] branch_addr_i,
    input  logic             jump_en_i,
    input  logic [AddrW-1:0] jump_addr_i,
    input  logic             reti_en_i,
    input  logic             hlt_instr_i,
    input  logic             stall_i,
    input  logic             irq_i,
    input  logic [AddrW-1:0] id_pc_i,
    output logic             start_o,
    output logic             pc_load_en_o,
    output logic [AddrW-1:0] pc_load_addr_o,
    output logic             pc_hold_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [AddrW-1:0] epc_o,
    output logic             in_isr_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e           state_q;
    logic             start_q;
    logic             in_isr_q;
    logic [AddrW-1:0] epc_q;
    logic [AddrW-1:0] halt_pc_q;

    // An interrupt may only be taken when not already servicing one.
    logic irq_ok;
    assign irq_ok = irq_i && !in_isr_q;

    // FSM state plus the registered bookkeeping (start, epc, in_isr, resume address).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            in_isr_q  <= 1'b0;
            epc_q     <= '0;
            halt_pc_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_req_i) begin
                        state_q <= StRun;
                        start_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (branch_en_i) begin
                        // Branch wins outright; nothing else changes.
                    end else if (reti_en_i) begin
                        if (in_isr_q) begin
                            in_isr_q <= 1'b0;
                        end
                    end else if (jump_en_i) begin
                        // Plain redirect, no bookkeeping.
                    end else if (irq_ok && !stall_i) begin
                        // The squashed ID instruction re-executes on return.
                        epc_q    <= id_pc_i;
                        in_isr_q <= 1'b1;
                    end else if (hlt_instr_i && !stall_i) begin
                        halt_pc_q <= id_pc_i + 1'b1;
                        state_q   <= StHalted;
                    end
                end
                StHalted: begin
                    if (irq_ok) begin
                        epc_q    <= halt_pc_q;
                        in_isr_q <= 1'b1;
                        state_q  <= StRun;
                    end else if (run_req_i) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Per-cycle fetch action and flush strobes, decoded from state and events.
    always_comb begin
        pc_load_en_o   = 1'b0;
        pc_load_addr_o = '0;
        pc_hold_o      = 1'b0;
        flush_ifid_o   = 1'b0;
        flush_idex_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pc_hold_o = 1'b1;
            end
            StRun: begin
                if (branch_en_i) begin
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = branch_addr_i;
                    flush_ifid_o   = 1'b1;
                    flush_idex_o   = 1'b1;
                end else if (reti_en_i) begin
                    // Outside an ISR this still behaves as a jump to epc.
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = epc_q;
                    flush_ifid_o   = 1'b1;
                end else if (jump_en_i) begin
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = jump_addr_i;
                    flush_ifid_o   = 1'b1;
                end else if (irq_ok && !stall_i) begin
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = IntVector;
                    flush_ifid_o   = 1'b1;
                end else if (hlt_instr_i && !stall_i) begin
                    pc_hold_o    = 1'b1;
                    flush_ifid_o = 1'b1;
                end else if (stall_i) begin
                    pc_hold_o = 1'b1;
                end
            end
            StHalted: begin
                if (irq_ok) begin
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = IntVector;
                    flush_ifid_o   = 1'b1;
                end else if (run_req_i) begin
                    pc_load_en_o   = 1'b1;
                    pc_load_addr_o = halt_pc_q;
                end else begin
                    pc_hold_o = 1'b1;
                end
            end
            default: begin
                pc_hold_o = 1'b1;
            end
        endcase
    end

    assign start_o  = start_q;
    assign epc_o    = epc_q;
    assign in_isr_o = in_isr_q;
    assign state_o  = state_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control unit for the 13-bit program counter of the 16-bit pipelined RISC core.
- Sequences fetch. Drives the counter's start, load-enable, load-address and hold inputs from run requests, EX-stage branches, ID-stage jumps, HLT, RETI, hazard stalls and a single-level interrupt.
- Generates IF/ID and ID/EX flush strobes.
- Keeps the interrupt return address (epc).

Parameters:
ADDR_W, 13, instruction address width
INT_VECTOR, 13'h1F00, interrupt service routine entry address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run_req  in  1  one-cycle pulse: begin execution from IDLE, or resume from HALTED
branch_en  in  1  taken branch resolved in EX
branch_addr  in  ADDR_W  branch target
jump_en  in  1  unconditional jump decoded in ID
jump_addr  in  ADDR_W  jump target
reti_en  in  1  RETI decoded in ID
hlt_instr  in  1  HLT decoded in ID
stall  in  1  load-use hazard; freeze fetch
irq  in  1  level-sensitive interrupt request
id_pc  in  ADDR_W  address of the instruction currently in ID
start  out  1  registered; PC runs when 1, PC forced to 0 when 0
pc_load_en  out  1  combinational; load pc_load_addr at next clk
pc_load_addr  out  ADDR_W  combinational load target
pc_hold  out  1  combinational; PC holds value at next clk
flush_ifid  out  1  combinational; squash IF/ID register
flush_idex  out  1  combinational; squash ID/EX register
epc  out  ADDR_W  registered interrupt return address
in_isr  out  1  registered; 1 while servicing an interrupt
state  out  2  registered FSM state: IDLE=0, RUN=1, HALTED=2

Behaviour:
Reset (async, any time, including mid-ISR or mid-branch):
- state=IDLE, start=0, epc=0, in_isr=0, halt_pc=0.
- Combinational outputs take their IDLE values immediately.

IDLE:
- Outputs: pc_hold=1, pc_load_en=0, flushes=0. All other inputs ignored.
- run_req -> RUN. start becomes 1 from the same edge, so the first fetch is from address 0.

RUN: exactly one action per cycle, in this priority order:
1. branch_en: pc_load_en=1, addr=branch_addr, flush_ifid=1, flush_idex=1. Overrides stall, jump, reti, irq, hlt in the same cycle.
2. reti_en && in_isr: load epc, flush_ifid=1, in_isr<=0. reti_en with in_isr=0 is treated as a jump to epc, and in_isr is unchanged.
3. jump_en: load jump_addr, flush_ifid=1.
4. irq && !in_isr && !stall: load INT_VECTOR, flush_ifid=1, epc<=id_pc (the squashed instruction re-executes on return), in_isr<=1.
5. hlt_instr && !stall: pc_hold=1, flush_ifid=1, halt_pc<=id_pc+1 (mod 2^13), state->HALTED.
6. stall: pc_hold=1, no flush.
7. Otherwise all outputs 0; the PC increments.

HALTED:
- Default: pc_hold=1, start stays 1.
- irq && !in_isr: load INT_VECTOR, epc<=halt_pc, in_isr<=1, flush_ifid=1, state->RUN.
- Else run_req: pc_load_en=1, addr=halt_pc, state->RUN.
- irq has priority over run_req in the same cycle.

Interrupt rules:
- No nesting: irq is ignored while in_isr=1 and stays pending as a level.
- An irq arriving in the same cycle as reti is taken at the next eligible cycle.

Invariants:
- pc_load_en and pc_hold are never both 1.
- flush_idex is asserted only for branches.
- Address arithmetic wraps mod 2^13 (0x1FFF+1=0).

Test Plan:
- Reset low, then high; run_req pulse -> start=1 next edge, state=1; with no events for 3 cycles all combinational outputs are 0 (PC counts 0,1,2).
- In RUN, branch_en=1, addr=0x0123, with jump_en=1, stall=1, irq=1 in the same cycle -> pc_load_en=1, pc_load_addr=0x0123, flush_ifid=flush_idex=1; in_isr stays 0 and epc stays 0.
- In RUN, irq=1, id_pc=0x0040 -> pc_load_addr=0x1F00, epc=0x0040, in_isr=1. Hold irq high: no re-entry. Later reti_en -> load 0x0040, in_isr=0; irq still high -> vector taken on the next non-stall cycle.
- hlt_instr with id_pc=0x1FFF -> pc_hold=1, flush_ifid=1, state=2, halt_pc=0x0000 (wrap). run_req -> load 0x0000, state=1.
- In HALTED, irq and run_req in the same cycle -> vector 0x1F00 loaded, epc=halt_pc, state=1.
- stall=1 with irq=1 for 2 cycles -> pc_hold=1, no flush, irq not taken; stall drops -> vector loaded. Assert reset mid-ISR -> state=0, start=0, in_isr=0, epc=0 asynchronously.
